// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector controller.
// Holds the controller state encoding and the pattern-length field width rule.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a field able to hold 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Host/serial-side bundle of the detector controller: configuration, start, data and status.
// The slave modport is the controller's view, master is the driver's view.
interface seq_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int FRAME_W = 8
);
    import seq_det_pkg::*;

    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] cfg_pat_i;
    logic [LEN_W-1:0]   cfg_len_i;
    logic               cfg_ovl_i;
    logic [FRAME_W-1:0] frame_len_i;
    logic               start_i;
    logic               x_i;
    logic               x_vld_i;
    logic               busy_o;
    logic               y_o;
    logic [CNT_W-1:0]   match_cnt_o;
    logic               done_o;
    logic               err_o;

    modport slave (
        input  cfg_pat_i, cfg_len_i, cfg_ovl_i, frame_len_i, start_i, x_i, x_vld_i,
        output busy_o, y_o, match_cnt_o, done_o, err_o
    );

    modport master (
        output cfg_pat_i, cfg_len_i, cfg_ovl_i, frame_len_i, start_i, x_i, x_vld_i,
        input  busy_o, y_o, match_cnt_o, done_o, err_o
    );

endinterface

// File: rtl/seq_match_core.sv
// History shift register and length-masked comparator for one pattern.
// hit_o is combinational on the incoming bit; the caller registers it.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               x_i,
    input  logic [MAX_LEN-1:0] pat_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               ovl_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_nx;
    logic [LEN_W-1:0]   hv_q, hv_d, hv_nx;
    logic [MAX_LEN:0]   shift_s;
    logic [MAX_LEN-1:0] mask_s;

    // Next history/depth, comparison and overlap handling
    always_comb begin
        shift_s = {hist_q, x_i};
        hist_nx = shift_s[MAX_LEN-1:0];
        if (hv_q >= len_i) begin
            hv_nx = len_i;
        end else begin
            hv_nx = hv_q + LEN_W'(1);
        end
        mask_s = ~({MAX_LEN{1'b1}} << len_i);
        hit_o  = en_i && (hv_nx == len_i) && (((hist_nx ^ pat_i) & mask_s) == '0);

        hist_d = hist_q;
        hv_d   = hv_q;
        if (clr_i) begin
            hist_d = '0;
            hv_d   = '0;
        end else if (en_i) begin
            hist_d = hist_nx;
            // Without overlap a match consumes all of its bits.
            if (hit_o && !ovl_i) begin
                hv_d = '0;
            end else begin
                hv_d = hv_nx;
            end
        end else begin
            hist_d = hist_q;
            hv_d   = hv_q;
        end
    end

    // History and valid-depth registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            hv_q   <= '0;
        end else begin
            hist_q <= hist_d;
            hv_q   <= hv_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Frame controller for serial pattern detection: config latch, frame sequencing,
// saturating match counter and registered status pulses.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int FRAME_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    seq_det_ctrl_if.slave bus
);

    localparam int LEN_W = len_w(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [FRAME_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               y_q, y_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               clr_s, en_s, hit_s, bad_cfg_s;

    seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_s),
        .en_i  (en_s),
        .x_i   (bus.x_i),
        .pat_i (pat_q),
        .len_i (len_q),
        .ovl_i (ovl_q),
        .hit_o (hit_s)
    );

    // Next-state, config latch, counters and output pulses
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        frame_d   = frame_q;
        bits_d    = bits_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        clr_s     = 1'b0;
        en_s      = (state_q == ST_RUN) && bus.x_vld_i;
        bad_cfg_s = (bus.cfg_len_i == '0) || (bus.cfg_len_i > LEN_W'(MAX_LEN))
                    || (bus.frame_len_i == '0);
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i && bad_cfg_s) begin
                    err_d = 1'b1;
                end else if (bus.start_i) begin
                    pat_d   = bus.cfg_pat_i;
                    len_d   = bus.cfg_len_i;
                    ovl_d   = bus.cfg_ovl_i;
                    frame_d = bus.frame_len_i;
                    bits_d  = '0;
                    cnt_d   = '0;
                    clr_s   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (en_s) begin
                    bits_d = bits_q + FRAME_W'(1);
                    if (hit_s && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (bits_d == frame_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        y_d    = hit_s;
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // State, config and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            frame_q <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            frame_q <= frame_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.y_o         = y_q;
    assign bus.match_cnt_o = cnt_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: main instance (CNT_W=8) and a narrow-counter instance (CNT_W=2).
module tb_seq_det_ctrl;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(8), .FRAME_W(8)) bus1 ();
    seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(2), .FRAME_W(8)) bus2 ();

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8), .FRAME_W(8)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(2), .FRAME_W(8)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic start1(input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic [7:0] frame);
        bus1.cfg_pat_i   = pat;
        bus1.cfg_len_i   = len;
        bus1.cfg_ovl_i   = ovl;
        bus1.frame_len_i = frame;
        bus1.start_i     = 1'b1;
        step();
        bus1.start_i     = 1'b0;
        bus1.cfg_len_i   = 4'd0;
        chk("start_busy", {31'd0, bus1.busy_o}, 32'd1);
        chk("start_err", {31'd0, bus1.err_o}, 32'd0);
        chk("start_cnt_clr", {24'd0, bus1.match_cnt_o}, 32'd0);
    endtask

    // Sends eight bits MSB first; exp_y gives the expected y_o after each bit.
    task automatic frame1(input logic [7:0] data, input logic [7:0] exp_y,
                          input bit gap, input logic [7:0] exp_cnt);
        for (int i = 0; i < 8; i++) begin
            bus1.x_i     = data[7-i];
            bus1.x_vld_i = 1'b1;
            step();
            bus1.x_vld_i = 1'b0;
            chk($sformatf("y_bit%0d", i + 1), {31'd0, bus1.y_o}, {31'd0, exp_y[7-i]});
            chk($sformatf("done_bit%0d", i + 1), {31'd0, bus1.done_o}, (i == 7) ? 32'd1 : 32'd0);
            chk($sformatf("busy_bit%0d", i + 1), {31'd0, bus1.busy_o}, 32'd1);
            if (gap && i < 7) begin
                bus1.x_i = ~data[7-i];
                step();
                chk("gap_y", {31'd0, bus1.y_o}, 32'd0);
                chk("gap_done", {31'd0, bus1.done_o}, 32'd0);
            end
        end
        bus1.x_i = 1'b0;
        step();
        chk("end_busy", {31'd0, bus1.busy_o}, 32'd0);
        chk("end_done", {31'd0, bus1.done_o}, 32'd0);
        chk("end_cnt", {24'd0, bus1.match_cnt_o}, {24'd0, exp_cnt});
    endtask

    task automatic bad_start(input logic [3:0] len, input logic [7:0] frame, input string tag);
        bus1.cfg_pat_i   = 8'h05;
        bus1.cfg_len_i   = len;
        bus1.cfg_ovl_i   = 1'b1;
        bus1.frame_len_i = frame;
        bus1.start_i     = 1'b1;
        step();
        bus1.start_i     = 1'b0;
        chk({tag, "_err"}, {31'd0, bus1.err_o}, 32'd1);
        chk({tag, "_busy"}, {31'd0, bus1.busy_o}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, bus1.match_cnt_o}, 32'd3);
        step();
        chk({tag, "_err_clr"}, {31'd0, bus1.err_o}, 32'd0);
        chk({tag, "_busy2"}, {31'd0, bus1.busy_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus1.cfg_pat_i = 8'h00; bus1.cfg_len_i = 4'd0; bus1.cfg_ovl_i = 1'b0;
        bus1.frame_len_i = 8'd0; bus1.start_i = 1'b0; bus1.x_i = 1'b0; bus1.x_vld_i = 1'b0;
        bus2.cfg_pat_i = 8'h00; bus2.cfg_len_i = 4'd0; bus2.cfg_ovl_i = 1'b0;
        bus2.frame_len_i = 8'd0; bus2.start_i = 1'b0; bus2.x_i = 1'b0; bus2.x_vld_i = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, bus1.busy_o}, 32'd0);
        chk("rst_y", {31'd0, bus1.y_o}, 32'd0);
        chk("rst_done", {31'd0, bus1.done_o}, 32'd0);
        chk("rst_err", {31'd0, bus1.err_o}, 32'd0);
        chk("rst_cnt", {24'd0, bus1.match_cnt_o}, 32'd0);
        rst = 1'b0;
        step();

        // 101 overlapping over 10101010: hits on bits 3,5,7
        start1(8'h05, 4'd3, 1'b1, 8'd8);
        frame1(8'b1010_1010, 8'b0010_1010, 1'b0, 8'd3);

        // Same stream without overlap: hits on bits 3,7
        start1(8'h05, 4'd3, 1'b0, 8'd8);
        frame1(8'b1010_1010, 8'b0010_0010, 1'b0, 8'd2);

        // Overlapping with idle cycles between valid bits
        start1(8'h05, 4'd3, 1'b1, 8'd8);
        frame1(8'b1010_1010, 8'b0010_1010, 1'b1, 8'd3);

        // Bad configurations leave the block idle and the count untouched
        bad_start(4'd0, 8'd8, "len0");
        bad_start(4'd9, 8'd8, "len9");
        bad_start(4'd3, 8'd0, "frame0");

        // Reset in the middle of a frame
        start1(8'h05, 4'd3, 1'b1, 8'd8);
        for (int i = 0; i < 4; i++) begin
            bus1.x_i     = (i % 2 == 0) ? 1'b1 : 1'b0;
            bus1.x_vld_i = 1'b1;
            step();
            bus1.x_vld_i = 1'b0;
            chk("mid_y", {31'd0, bus1.y_o}, (i == 2) ? 32'd1 : 32'd0);
        end
        chk("mid_cnt", {24'd0, bus1.match_cnt_o}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, bus1.busy_o}, 32'd0);
        chk("mrst_y", {31'd0, bus1.y_o}, 32'd0);
        chk("mrst_done", {31'd0, bus1.done_o}, 32'd0);
        chk("mrst_cnt", {24'd0, bus1.match_cnt_o}, 32'd0);
        step();
        chk("mrst_idle", {31'd0, bus1.busy_o}, 32'd0);
        start1(8'h05, 4'd3, 1'b1, 8'd8);
        frame1(8'b1010_1010, 8'b0010_1010, 1'b0, 8'd3);

        // Narrow counter: single-bit pattern on all ones saturates at 3
        bus2.cfg_pat_i   = 8'h01;
        bus2.cfg_len_i   = 4'd1;
        bus2.cfg_ovl_i   = 1'b1;
        bus2.frame_len_i = 8'd8;
        bus2.start_i     = 1'b1;
        step();
        bus2.start_i = 1'b0;
        chk("sat_busy", {31'd0, bus2.busy_o}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus2.x_i     = 1'b1;
            bus2.x_vld_i = 1'b1;
            step();
            bus2.x_vld_i = 1'b0;
            chk($sformatf("sat_y%0d", i + 1), {31'd0, bus2.y_o}, 32'd1);
            chk($sformatf("sat_cnt%0d", i + 1), {30'd0, bus2.match_cnt_o},
                (i >= 2) ? 32'd3 : 32'(i + 1));
            chk($sformatf("sat_done%0d", i + 1), {31'd0, bus2.done_o}, (i == 7) ? 32'd1 : 32'd0);
        end
        step();
        chk("sat_end_busy", {31'd0, bus2.busy_o}, 32'd0);
        chk("sat_end_cnt", {30'd0, bus2.match_cnt_o}, 32'd3);
        chk("sat_end_y", {31'd0, bus2.y_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
